// File: rtl/game_pkg.sv
// Shared types and default tuning constants for the game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_e;

  localparam int SCORE_W_DEF     = 16;
  localparam int HIT_FRAMES_DEF  = 60;
  localparam int OVER_FRAMES_DEF = 120;
  localparam int FLASH_SH_DEF    = 3;
  localparam int FCNT_W          = 8;

endpackage

// File: rtl/game_ctrl_rise_detect.sv
// Single-bit rising-edge detector with a configurable delay-flop reset value.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= RST_VAL;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow sequencer: IDLE/PLAY/HIT/OVER, scoring and barry control.
module game_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int HIT_FRAMES  = HIT_FRAMES_DEF,
  parameter int OVER_FRAMES = OVER_FRAMES_DEF,
  parameter int FLASH_SH    = FLASH_SH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               fly_btn,
  input  logic               frame_tick,
  input  logic               collide,
  output logic               barry_rst,
  output logic               barry_in,
  output logic               scroll_en,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [1:0]         state_o,
  output logic               hit_flash,
  output logic               game_over
);

  localparam logic [FCNT_W-1:0]  HIT_LAST  = FCNT_W'(HIT_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  OVER_LAST = FCNT_W'(OVER_FRAMES);
  localparam logic [FCNT_W-1:0]  FCNT_ONE  = FCNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  game_state_e        state_q;
  logic [FCNT_W-1:0]  fcnt_q;
  logic [FCNT_W-1:0]  fcnt_inc;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] high_q;
  logic               barry_rst_q;
  logic               barry_in_q;
  logic               scroll_q;
  logic               flash_q;
  logic               over_q;
  logic               start_rise;

  // Delay flop resets high so a button held through reset gives no edge
  rise_detect #(.RST_VAL(1'b1)) u_start_rise (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (start_btn),
    .rise_o (start_rise)
  );

  assign fcnt_inc = fcnt_q + FCNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      score_q     <= '0;
      high_q      <= '0;
      barry_rst_q <= 1'b1;
      barry_in_q  <= 1'b0;
      scroll_q    <= 1'b0;
      flash_q     <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q     <= PLAY;
            score_q     <= '0;
            fcnt_q      <= '0;
            barry_rst_q <= 1'b0;
            scroll_q    <= 1'b1;
            barry_in_q  <= fly_btn;
          end
        end
        PLAY: begin
          if (collide) begin
            state_q    <= HIT;
            fcnt_q     <= '0;
            scroll_q   <= 1'b0;
            barry_in_q <= 1'b0;
            flash_q    <= 1'b0;
          end else begin
            barry_in_q <= fly_btn;
            if (frame_tick && score_q != '1)
              score_q <= score_q + SCORE_ONE;
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (fcnt_q == HIT_LAST) begin
              state_q <= OVER;
              fcnt_q  <= '0;
              flash_q <= 1'b0;
              over_q  <= 1'b1;
              if (score_q > high_q)
                high_q <= score_q;
            end else begin
              fcnt_q  <= fcnt_inc;
              flash_q <= fcnt_inc[FLASH_SH];
            end
          end
        end
        OVER: begin
          if (frame_tick && fcnt_q != OVER_LAST)
            fcnt_q <= fcnt_inc;
          // Early presses are dropped, not remembered
          if (start_rise && fcnt_q == OVER_LAST) begin
            state_q     <= IDLE;
            barry_rst_q <= 1'b1;
            over_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o    = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign barry_rst  = barry_rst_q;
  assign barry_in   = barry_in_q;
  assign scroll_en  = scroll_q;
  assign hit_flash  = flash_q;
  assign game_over  = over_q;

endmodule
